// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: control-path pipeline register for an inter-stage boundary.
// It carries a packed control word and a valid bit, and supports stall (hold)
// and clear (flush to bubble). After a reset or clear it blanks the stage for
// FLUSH_HOLD cycles. bubble_cnt is a saturating count of inserted bubble
// cycles. Updates happen on the falling edge when NEG_EDGE=1, otherwise on
// the rising edge.
module pipe_stage_ctrl #(
    parameter int unsigned    W            = 32,
    parameter logic [W-1:0]   BUBBLE_VAL   = '0,
    parameter int unsigned    FLUSH_HOLD   = 1,
    parameter bit             NEG_EDGE     = 1'b1,
    parameter bit             ZERO_INVALID = 1'b1,
    parameter int unsigned    CW           = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          stall,
    input  logic          valid_d,
    input  logic [W-1:0]  data_d,
    output logic          valid_e,
    output logic [W-1:0]  data_e,
    output logic          blanking,
    output logic [CW-1:0] bubble_cnt
);

    localparam logic [3:0]    HOLD_INIT = 4'(FLUSH_HOLD);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    logic [W-1:0]  data_e_d,     data_e_q;
    logic          valid_e_d,    valid_e_q;
    logic [3:0]    hold_cnt_d,   hold_cnt_q;
    logic [CW-1:0] bubble_cnt_d, bubble_cnt_q;
    logic [CW-1:0] bubble_inc;

    // Saturating increment of the bubble counter; it never wraps.
    always_comb begin
        bubble_inc = bubble_cnt_q;
        if (bubble_cnt_q != CNT_MAX) begin
            bubble_inc = bubble_cnt_q + CW'(1);
        end
    end

    // Next-state selection: reset > clear > blanking > stall > load.
    always_comb begin
        data_e_d     = data_e_q;
        valid_e_d    = valid_e_q;
        hold_cnt_d   = hold_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!reset) begin
            data_e_d     = BUBBLE_VAL;
            valid_e_d    = 1'b0;
            hold_cnt_d   = HOLD_INIT;
            bubble_cnt_d = '0;
        end else if (clear) begin
            data_e_d     = BUBBLE_VAL;
            valid_e_d    = 1'b0;
            hold_cnt_d   = HOLD_INIT;
            bubble_cnt_d = bubble_inc;
        end else if (hold_cnt_q != 4'd0) begin
            // Blanking window: the stage stays a bubble regardless of stall.
            data_e_d     = BUBBLE_VAL;
            valid_e_d    = 1'b0;
            hold_cnt_d   = hold_cnt_q - 4'd1;
            bubble_cnt_d = bubble_inc;
        end else if (!stall) begin
            valid_e_d = valid_d;
            if (!valid_d && ZERO_INVALID) begin
                data_e_d = BUBBLE_VAL;
            end else begin
                data_e_d = data_d;
            end
        end
    end

    // State register on the clock edge chosen at elaboration time.
    if (NEG_EDGE) begin : g_neg_edge
        // Falling-edge state update.
        always_ff @(negedge clk) begin
            data_e_q     <= data_e_d;
            valid_e_q    <= valid_e_d;
            hold_cnt_q   <= hold_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end else begin : g_pos_edge
        // Rising-edge state update.
        always_ff @(posedge clk) begin
            data_e_q     <= data_e_d;
            valid_e_q    <= valid_e_d;
            hold_cnt_q   <= hold_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign data_e     = data_e_q;
    assign valid_e    = valid_e_q;
    assign blanking   = (hold_cnt_q != 4'd0);
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Testbench for pipe_stage_ctrl. Four differently configured instances share
// one stimulus stream, and each is compared against a reference model after
// every rising and every falling clock edge:
//   u0: FLUSH_HOLD=2, falling edge, ZERO_INVALID=1, BUBBLE_VAL=EE
//   u1: legacy D->E form (FLUSH_HOLD=1, falling edge, ZERO_INVALID=0)
//   u2: FLUSH_HOLD=3, rising edge, BUBBLE_VAL=05
//   u3: FLUSH_HOLD=0, rising edge, CW=2 (bubble counter saturation)
module tb_pipe_stage_ctrl;

    logic       clk = 1'b0;
    logic       reset, clear, stall, valid_d;
    logic [7:0] data_d;

    logic [7:0]  de0, de1, de2, de3;
    logic        ve0, ve1, ve2, ve3;
    logic        bl0, bl1, bl2, bl3;
    logic [15:0] bc0, bc1, bc2;
    logic [1:0]  bc3;

    logic [7:0]  obs_data  [4];
    logic        obs_valid [4];
    logic        obs_blank [4];
    logic [15:0] obs_bub   [4];

    assign obs_data[0] = de0;  assign obs_data[1] = de1;
    assign obs_data[2] = de2;  assign obs_data[3] = de3;
    assign obs_valid[0] = ve0; assign obs_valid[1] = ve1;
    assign obs_valid[2] = ve2; assign obs_valid[3] = ve3;
    assign obs_blank[0] = bl0; assign obs_blank[1] = bl1;
    assign obs_blank[2] = bl2; assign obs_blank[3] = bl3;
    assign obs_bub[0] = bc0;   assign obs_bub[1] = bc1;
    assign obs_bub[2] = bc2;   assign obs_bub[3] = {14'd0, bc3};

    // Per-instance configuration, as seen by the reference model.
    int         cfg_hold [4] = '{2, 1, 3, 0};
    int         cfg_neg  [4] = '{1, 1, 0, 0};
    int         cfg_zi   [4] = '{1, 0, 1, 1};
    logic [7:0] cfg_bv   [4] = '{8'hEE, 8'h00, 8'h05, 8'hFF};
    int         cfg_max  [4] = '{65535, 65535, 65535, 3};

    // Reference model state.
    logic [7:0] m_data  [4];
    bit         m_valid [4];
    int         m_left  [4];
    int         m_bub   [4];

    int checks = 0;
    int errors = 0;

    pipe_stage_ctrl #(.W(8), .BUBBLE_VAL(8'hEE), .FLUSH_HOLD(2), .NEG_EDGE(1'b1),
                      .ZERO_INVALID(1'b1), .CW(16)) u0 (
        .clk(clk), .reset(reset), .clear(clear), .stall(stall), .valid_d(valid_d),
        .data_d(data_d), .valid_e(ve0), .data_e(de0), .blanking(bl0), .bubble_cnt(bc0));

    pipe_stage_ctrl #(.W(8), .BUBBLE_VAL(8'h00), .FLUSH_HOLD(1), .NEG_EDGE(1'b1),
                      .ZERO_INVALID(1'b0), .CW(16)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .stall(stall), .valid_d(valid_d),
        .data_d(data_d), .valid_e(ve1), .data_e(de1), .blanking(bl1), .bubble_cnt(bc1));

    pipe_stage_ctrl #(.W(8), .BUBBLE_VAL(8'h05), .FLUSH_HOLD(3), .NEG_EDGE(1'b0),
                      .ZERO_INVALID(1'b1), .CW(16)) u2 (
        .clk(clk), .reset(reset), .clear(clear), .stall(stall), .valid_d(valid_d),
        .data_d(data_d), .valid_e(ve2), .data_e(de2), .blanking(bl2), .bubble_cnt(bc2));

    pipe_stage_ctrl #(.W(8), .BUBBLE_VAL(8'hFF), .FLUSH_HOLD(0), .NEG_EDGE(1'b0),
                      .ZERO_INVALID(1'b1), .CW(2)) u3 (
        .clk(clk), .reset(reset), .clear(clear), .stall(stall), .valid_d(valid_d),
        .data_d(data_d), .valid_e(ve3), .data_e(de3), .blanking(bl3), .bubble_cnt(bc3));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One active edge of instance k, following the stage's rule list.
    task automatic model_edge(input int k);
        if (!reset) begin
            m_data[k]  = cfg_bv[k];
            m_valid[k] = 1'b0;
            m_left[k]  = cfg_hold[k];
            m_bub[k]   = 0;
        end else if (clear) begin
            m_data[k]  = cfg_bv[k];
            m_valid[k] = 1'b0;
            m_left[k]  = cfg_hold[k];
            m_bub[k]   = (m_bub[k] + 1 > cfg_max[k]) ? cfg_max[k] : m_bub[k] + 1;
        end else if (m_left[k] > 0) begin
            m_left[k]  = m_left[k] - 1;
            m_bub[k]   = (m_bub[k] + 1 > cfg_max[k]) ? cfg_max[k] : m_bub[k] + 1;
        end else if (!stall) begin
            m_valid[k] = valid_d;
            m_data[k]  = (!valid_d && cfg_zi[k] == 1) ? cfg_bv[k] : data_d;
        end
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("%s_u%0d_valid", ph, k), 32'(obs_valid[k]), 32'(m_valid[k]));
            check_eq($sformatf("%s_u%0d_data", ph, k), 32'(obs_data[k]), 32'(m_data[k]));
            check_eq($sformatf("%s_u%0d_blank", ph, k), 32'(obs_blank[k]), 32'(m_left[k] != 0));
            check_eq($sformatf("%s_u%0d_bubcnt", ph, k), 32'(obs_bub[k]), 32'(m_bub[k]));
        end
    endtask

    // Inputs are applied just after a falling edge, held across the next
    // rising and falling edges, and all instances are checked after each.
    task automatic do_step(input logic r, input logic c, input logic s,
                           input logic vd, input logic [7:0] dd);
        reset = r; clear = c; stall = s; valid_d = vd; data_d = dd;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) if (cfg_neg[k] == 0) model_edge(k);
        check_all("pos");
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) if (cfg_neg[k] == 1) model_edge(k);
        check_all("neg");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; clear = 1'b0; stall = 1'b0; valid_d = 1'b0; data_d = 8'h00;
        #21;
        for (int k = 0; k < 4; k++) model_edge(k);

        // Reset held for two steps, then released with A5 waiting.
        do_step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
        do_step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
        check_eq("rst_u0_blank_held", 32'(bl0), 32'd1);
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
        check_eq("rst_u0_still_bubble", 32'(ve0), 32'd0);
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
        check_eq("rst_u0_data", 32'(de0), 32'hA5);
        check_eq("rst_u0_valid", 32'(ve0), 32'd1);
        check_eq("rst_u0_bubcnt", 32'(bc0), 32'd2);

        // Stream, then stall for three steps.
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 8'h22);
        for (int i = 0; i < 3; i++) do_step(1'b1, 1'b0, 1'b1, 1'b1, 8'h33);
        check_eq("stall_u0_hold", 32'(de0), 32'h22);
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 8'h33);
        check_eq("stall_u0_release", 32'(de0), 32'h33);
        check_eq("stall_u0_bubcnt", 32'(bc0), 32'd2);

        // Clear together with stall.
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 8'h44);
        do_step(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
        check_eq("clrstall_u0_data", 32'(de0), 32'hEE);
        check_eq("clrstall_u0_bubcnt", 32'(bc0), 32'd3);

        // Clear restarting an active blanking window.
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 8'h60);
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 8'h60);
        do_step(1'b1, 1'b1, 1'b0, 1'b1, 8'h61);
        do_step(1'b1, 1'b1, 1'b0, 1'b1, 8'h62);
        for (int i = 0; i < 3; i++) do_step(1'b1, 1'b0, 1'b0, 1'b1, 8'h66);
        check_eq("restart_u2_blank", 32'(bl2), 32'd0);
        check_eq("restart_u2_bubble", 32'(ve2), 32'd0);
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 8'h66);
        check_eq("restart_u2_load", 32'(de2), 32'h66);

        // Legacy form: one bubble, then an invalid word passes through.
        do_step(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
        do_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
        check_eq("legacy_u1_bubble", 32'(de1), 32'h00);
        do_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
        check_eq("legacy_u1_data", 32'(de1), 32'h5A);
        check_eq("legacy_u1_valid", 32'(ve1), 32'd0);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) do_step(1'b1, 1'b1, 1'b0, 1'b1, 8'h77);
        check_eq("sat_u3_bubcnt", 32'(bc3), 32'd3);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            do_step(($urandom_range(39) != 0), ($urandom_range(7) == 0),
                    ($urandom_range(3) == 0), ($urandom_range(3) != 0),
                    8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
